// File: rtl/dispatch_queue_if.sv
// Handshake bundle between fetch/dispatch and the dispatch queue.
// The slave modport is the queue side; the master modport is the fetch/dispatch side.
interface dispatch_queue_if #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int PKT_W = 96
);
  localparam int BW    = $clog2(WIDTH + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   squash;
  logic [WIDTH-1:0]       enq_valid;
  logic [WIDTH*PKT_W-1:0] enq_pkt;
  logic [WIDTH-1:0]       enq_pred_taken;
  logic [WIDTH-1:0]       enq_halt;
  logic                   enq_ready;
  logic [BW-1:0]          deq_budget;
  logic [WIDTH-1:0]       deq_valid;
  logic [WIDTH*PKT_W-1:0] deq_pkt;
  logic [BW-1:0]          deq_count;
  logic [CNT_W-1:0]       count;
  logic                   halted;

  modport master (
    output squash, enq_valid, enq_pkt, enq_pred_taken, enq_halt, deq_budget,
    input  enq_ready, deq_valid, deq_pkt, deq_count, count, halted
  );

  modport slave (
    input  squash, enq_valid, enq_pkt, enq_pred_taken, enq_halt, deq_budget,
    output enq_ready, deq_valid, deq_pkt, deq_count, count, halted
  );
endinterface

// File: rtl/dispatch_queue.sv
// In-order N-wide instruction buffer between fetch and dispatch/rename.
// Truncates after predicted-taken, compacts into age order, blocks on halt, flushes on squash.
module dispatch_queue #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int PKT_W = 96
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dispatch_queue_if.slave dq_if
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BW    = $clog2(WIDTH + 1);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [PKT_W-1:0] mem_pkt_q  [DEPTH];
  logic             mem_halt_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [0:0]       state_q, state_d;

  logic             enq_ready;
  logic             do_enq;
  logic [WIDTH-1:0] keep;
  logic [BW-1:0]    enq_off [WIDTH];
  logic [BW-1:0]    kept_cnt;
  logic [BW-1:0]    enq_kept;
  logic [PTR_W-1:0] wr_addr [WIDTH];

  logic [PTR_W-1:0] rd_addr [WIDTH];
  logic [WIDTH-1:0] rd_halt;
  logic [WIDTH-1:0] deq_sel;
  logic [BW-1:0]    halt_lim;
  logic [BW-1:0]    budget_eff;
  logic [BW-1:0]    n_lim;
  logic [BW-1:0]    deq_n;
  logic             halt_hit;

  // Space check uses registered count only; a same-cycle dequeue never frees room.
  assign enq_ready = (state_q == ST_RUN) && (count_q <= CNT_W'(DEPTH - WIDTH));
  assign do_enq    = enq_ready && !dq_if.squash;

  // Keep valid slots from oldest down to and including the first predicted-taken one.
  always_comb begin
    logic stop;
    keep = '0;
    stop = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (dq_if.enq_valid[i] && !stop) begin
        keep[i] = 1'b1;
        if (dq_if.enq_pred_taken[i]) begin
          stop = 1'b1;
        end
      end
    end
  end

  // Each kept slot lands at tail plus the number of older kept slots.
  always_comb begin
    logic [BW-1:0] acc;
    acc = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      enq_off[i] = acc;
      if (keep[i]) begin
        acc = acc + BW'(1);
      end
    end
    kept_cnt = acc;
  end

  assign enq_kept = do_enq ? kept_cnt : '0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addr
      assign wr_addr[gi] = tail_q + PTR_W'(enq_off[gi]);
      assign rd_addr[gi] = head_q + PTR_W'(gi);
      assign rd_halt[gi] = mem_halt_q[rd_addr[gi]];
    end
  endgenerate

  // Dispatch stops just after the first halt among the oldest WIDTH entries.
  always_comb begin
    logic found;
    halt_lim = BW'(WIDTH);
    found    = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (!found && rd_halt[k]) begin
        halt_lim = BW'(k + 1);
        found    = 1'b1;
      end
    end
  end

  assign budget_eff = (dq_if.deq_budget > BW'(WIDTH)) ? BW'(WIDTH) : dq_if.deq_budget;
  assign n_lim      = (budget_eff < halt_lim) ? budget_eff : halt_lim;

  always_comb begin
    deq_n = n_lim;
    if (CNT_W'(n_lim) > count_q) begin
      deq_n = BW'(count_q);
    end
    if (state_q == ST_HALTED || dq_if.squash) begin
      deq_n = '0;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deq
      assign deq_sel[gi] = (BW'(gi) < deq_n);
      assign dq_if.deq_valid[WIDTH-1-gi] = deq_sel[gi];
      assign dq_if.deq_pkt[(WIDTH-1-gi)*PKT_W +: PKT_W] =
        deq_sel[gi] ? mem_pkt_q[rd_addr[gi]] : '0;
    end
  endgenerate

  assign halt_hit = |(rd_halt & deq_sel);

  always_comb begin
    head_d  = head_q + PTR_W'(deq_n);
    tail_d  = tail_q + PTR_W'(enq_kept);
    count_d = count_q + CNT_W'(enq_kept) - CNT_W'(deq_n);
    state_d = halt_hit ? ST_HALTED : state_q;
    if (dq_if.squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= ST_RUN;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Entry storage carries no reset; offsets are distinct so writes never collide.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (do_enq && keep[i]) begin
        mem_pkt_q[wr_addr[i]]  <= dq_if.enq_pkt[i*PKT_W +: PKT_W];
        mem_halt_q[wr_addr[i]] <= dq_if.enq_halt[i];
      end
    end
  end

  assign dq_if.enq_ready = enq_ready;
  assign dq_if.deq_count = deq_n;
  assign dq_if.count     = count_q;
  assign dq_if.halted    = (state_q == ST_HALTED);
endmodule
